uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 116 +++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte queue behind a UART 8N1 receiver that counts held newlines and flags overruns.
// Latency: a byte written at edge N shows on rd_data/level/flags after edge N (first-word-fall-through).
// Backpressure: none upstream; a byte offered while full without a pop is dropped and overrun is set.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  input  logic          rd_en,
  input  logic          clr_overrun,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overrun,
  output logic [AW:0]   line_count,
  output logic          line_ready
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [7:0]  LP_NL    = 8'h0A;

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0] r_level;
  logic [AW:0] r_line_count;
  logic        r_overrun;

  logic        w_empty;
  logic        w_full;
  logic        w_wr;
  logic        w_pop;
  logic        w_drop;
  logic [7:0]  w_head;
  logic        w_nl_in;
  logic        w_nl_out;

  // Flags come straight from the registered count, so no input reaches them combinationally.
  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LP_DEPTH);
  // A pop frees a slot in the same edge, so a full queue still accepts a byte when rd_en is high.
  assign w_pop    = rd_en && !w_empty;
  assign w_wr     = in_valid && (!w_full || rd_en);
  assign w_drop   = in_valid && w_full && !rd_en;
  assign w_head   = r_mem[r_rd_ptr];
  assign w_nl_in  = w_wr && (in_byte == LP_NL);
  assign w_nl_out = w_pop && (w_head == LP_NL);

  // Storage write; contents are never reset, a write during reset is abandoned.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
      r_mem[r_wr_ptr] <= in_byte;
    end
  end

  // Pointers and byte count; write-and-pop together leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Count of 0x0A bytes held; only accepted writes and real pops move it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_count <= '0;
    end else begin
      case ({w_nl_in, w_nl_out})
        2'b10:   r_line_count <= r_line_count + (AW+1)'(1);
        2'b01:   r_line_count <= r_line_count - (AW+1)'(1);
        default: r_line_count <= r_line_count;
      endcase
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  // Head byte is masked to zero while empty so stale memory never leaks out.
  always_comb begin
    rd_data    = w_empty ? 8'h00 : w_head;
    empty      = w_empty;
    full       = w_full;
    level      = r_level;
    overrun    = r_overrun;
    line_count = r_line_count;
    line_ready = (r_line_count != '0);
  end

endmodule
